// File: rtl/multiword_add_pkg.sv
// Shared types and default sizing for the multi-word adder sequencer.
// A word of B*N bits is added one B-bit slice per clock.
package multiword_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int B_DEF = 4;
    localparam int N_DEF = 4;

endpackage

// File: rtl/ripple_carry_B_bit.sv
// B-bit ripple-carry adder slice with a group propagate flag.
// Purely combinational; the sequencer chains carries across clock cycles.
module ripple_carry_B_bit #(
    parameter int B = 4
) (
    input  logic [B-1:0] a,
    input  logic [B-1:0] b,
    input  logic         cin,
    output logic [B-1:0] sum,
    output logic         cout,
    output logic         p
);

    logic [B:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < B; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
        end
    end

    assign cout = c[B];
    // The slice propagates a carry straight through only if every bit differs.
    assign p    = &(a ^ b);

endmodule

// File: rtl/multiword_add_ctrl.sv
// Adds two B*N-bit words by running one shared B-bit adder slice over N cycles,
// LSB slice first, with the inter-slice carry held in a register.
module multiword_add_ctrl
    import multiword_add_pkg::*;
#(
    parameter int B  = B_DEF,
    parameter int N  = N_DEF,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [B*N-1:0] a,
    input  logic [B*N-1:0] b,
    input  logic           cin,
    output logic           busy,
    output logic           done,
    output logic [B*N-1:0] sum,
    output logic           cout,
    output logic           p,
    output state_t         state_dbg
);

    localparam int W = B * N;

    // Handshake: start is sampled only in IDLE or DONE (busy low); an accepted
    // start captures a, b and cin. done pulses for one cycle when sum, cout and p
    // are final, and they hold until the next accepted start. start during RUN
    // is dropped, not queued.

    state_t         state;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           carry_r;
    logic           p_acc;
    logic [CW-1:0]  idx;
    logic [W-1:0]   sum_r;
    logic           cout_r;
    logic           p_r;

    logic [B-1:0]   sl_a;
    logic [B-1:0]   sl_b;
    logic [B-1:0]   sl_sum;
    logic           sl_cout;
    logic           sl_p;

    assign sl_a = a_r[int'(idx) * B +: B];
    assign sl_b = b_r[int'(idx) * B +: B];

    ripple_carry_B_bit #(.B(B)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_r),
        .sum  (sl_sum),
        .cout (sl_cout),
        .p    (sl_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            p_acc   <= 1'b0;
            idx     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            p_r     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        p_acc   <= 1'b1;
                        idx     <= '0;
                        state   <= RUN;
                    end else begin
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    sum_r[int'(idx) * B +: B] <= sl_sum;
                    carry_r <= sl_cout;
                    p_acc   <= p_acc & sl_p;
                    // idx only wraps through the IDLE/DONE capture, never by overflow.
                    if (idx == CW'(N - 1)) begin
                        cout_r <= sl_cout;
                        p_r    <= p_acc & sl_p;
                        state  <= DONE;
                    end else begin
                        idx    <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign p         = p_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed-vector bench for multiword_add_ctrl with B = 4, N = 4.
// Each scenario task drives stimulus and checks hand-computed results inline.
module tb_multiword_add_ctrl;
    import multiword_add_pkg::*;

    localparam int B = 4;
    localparam int N = 4;
    localparam int W = B * N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         p;
    state_t       state_dbg;

    int vectors;
    int miscompares;
    logic [W-1:0] exp_q[$];

    multiword_add_ctrl #(.B(B), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .p         (p),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation and check latency, result and the hold after done.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                          input logic [W-1:0] esum, input logic ecout, input logic ep,
                          input string name);
        int lat;
        a = va; b = vb; cin = vc; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~va; b = ~vb; cin = ~vc;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_busy: got %b expected 1", name, busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d cycles expected 4", name, lat);
        end
        vectors++;
        if (sum !== esum || cout !== ecout || p !== ep) begin
            miscompares++;
            $display("FAIL %s_result: got sum=%h cout=%b p=%b expected sum=%h cout=%b p=%b",
                     name, sum, cout, p, esum, ecout, ep);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== esum || state_dbg !== IDLE) begin
            miscompares++;
            $display("FAIL %s_hold: got done=%b busy=%b sum=%h state=%0d expected done=0 busy=0 sum=%h state=0",
                     name, done, busy, sum, state_dbg, esum);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || p !== 1'b0
            || state_dbg !== IDLE) begin
            miscompares++;
            $display("FAIL reset: got busy=%b done=%b sum=%h cout=%b p=%b state=%0d expected all 0",
                     busy, done, sum, cout, p, state_dbg);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        run_op(16'h9696, 16'h6969, 1'b0, 16'hFFFF, 1'b0, 1'b1, "alt_pattern");
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "full_ripple");
        run_op(16'hDADA, 16'hC9C9, 1'b1, 16'hA4A4, 1'b1, 1'b0, "carry_in");
    endtask

    task automatic test_ignore_restart();
        int busy_cnt;
        int done_cnt;
        a = 16'h1234; b = 16'h0101; cin = 1'b0; start = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                a = 16'h0001; b = 16'h0001;
            end
            if (i == 2) start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                vectors++;
                if (sum !== 16'h1335 || cout !== 1'b0) begin
                    miscompares++;
                    $display("FAIL restart_result: got sum=%h cout=%b expected sum=1335 cout=0", sum, cout);
                end
            end
        end
        vectors++;
        if (busy_cnt !== 4) begin
            miscompares++;
            $display("FAIL restart_busy: got %0d busy cycles expected 4", busy_cnt);
        end
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL restart_done: got %0d done pulses expected 1", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int last_done;
        logic [W-1:0] exp;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(16'h2345);
        last_done = -1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra_done: got done at cycle %0d expected none", i);
                end else begin
                    exp = exp_q.pop_front();
                    if (sum !== exp || cout !== 1'b0) begin
                        miscompares++;
                        $display("FAIL b2b_result: got sum=%h cout=%b expected sum=%h cout=0", sum, cout, exp);
                    end
                end
                vectors++;
                if (i - last_done !== 5) begin
                    miscompares++;
                    $display("FAIL b2b_spacing: got %0d cycles since previous expected 5", i - last_done);
                end
                last_done = i;
            end
        end
        start = 1'b0;
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results missing expected 0", exp_q.size());
            exp_q.delete();
        end
        tick();
        vectors++;
        if (state_dbg !== IDLE || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got state=%0d busy=%b expected state=0 busy=0", state_dbg, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || p !== 1'b0
            || state_dbg !== IDLE) begin
            miscompares++;
            $display("FAIL mid_reset: got busy=%b done=%b sum=%h cout=%b p=%b state=%0d expected all 0",
                     busy, done, sum, cout, p, state_dbg);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_ignore_restart();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multiword_add_ctrl.md
Name: multiword_add_ctrl

Overview:
Sequencer that adds W = B*N-bit operands by reusing one B-bit ripple-carry adder slice (`ripple_carry_B_bit`) over N consecutive clock cycles. It processes the LSB slice first. The carry is registered between slices, and slice propagate flags are accumulated into a word-level propagate. It sits between a requesting datapath (start/done handshake) and the shared adder slice, trading latency for area.

Parameters:
- B, 4, adder slice width in bits. Must match the width of the instantiated slice.
- N, 4, number of slices per operation, N >= 1. Operand width W = B*N.
- CW, $clog2(N) (1 when N = 1), slice index counter width.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request pulse. Sampled only when not busy.
- a, input, W, operand A. Captured on an accepted start.
- b, input, W, operand B. Captured on an accepted start.
- cin, input, 1, carry-in. Captured on an accepted start.
- busy, output, 1, high while the operation is in progress.
- done, output, 1, one-cycle pulse when the result is valid.
- sum, output, W, result. Held until the next accepted start.
- cout, output, 1, carry out of the MSB slice. Held with sum.
- p, output, 1, word propagate (AND of all slice p). Held with sum.

Behaviour:
- Reset, asynchronous and active-low. State = IDLE; busy = 0, done = 0, sum = 0, cout = 0, p = 0; internal operand registers, carry and index cleared.
- States:
  - IDLE: start = 1 → capture a, b, cin; idx = 0; p_acc = 1; go to RUN.
  - RUN: each cycle, slice inputs = a_r[idx*B +: B], b_r[idx*B +: B], carry_r. At the edge:
    - sum[idx*B +: B] <= slice sum
    - carry_r <= slice cout
    - p_acc <= p_acc & slice p
    - idx <= idx + 1
    - When idx == N-1: cout <= slice cout, p <= p_acc & slice p; go to DONE.
  - DONE: done = 1 for exactly this cycle. Go to IDLE, or to RUN if start = 1 (back-to-back accept, with capture as in IDLE).
- busy = 1 in RUN only. done = 1 in DONE only. Both are registered-state decodes with no combinational path from start.
- Latency: start accepted at edge k → RUN for edges k+1..k+N → done high in the cycle after edge k+N. Throughput is one operation per N+1 cycles.
- start while in RUN: ignored. Operands are not re-captured and there is no queueing.
- Changes on a, b or cin after capture: no effect on the operation in flight.
- sum is updated slice by slice during RUN. Consumers read it only when done = 1 or after done. In IDLE it holds the last result.
- Idx wraps only via the state change. It never indexes beyond slice N-1.
- Reset asserted mid-RUN: immediately abort to the reset values. No done pulse is produced; the partial sum is discarded (cleared).
- Arithmetic: unsigned modulo 2^W; cout is the true carry out of bit W-1. No overflow flag.

Decomposition:
- Shared package `multiword_add_pkg`:
  - state enum {IDLE, RUN, DONE} (2-bit encoding)
  - default constants B_DEF = 4, N_DEF = 4
- One sub-module: the existing `ripple_carry_B_bit` adder slice, instantiated once and unmodified. The controller contains only the FSM, the operand, carry and p_acc registers, and the result register.

Test Plan (B = 4, N = 4):
- a = 0x9696, b = 0x6969, cin = 0, start pulse → done in cycle 5 after start; sum = 0xFFFF, cout = 0, p = 1.
- a = 0xFFFF, b = 0x0001, cin = 0 → sum = 0x0000, cout = 1, p = 0. Carry ripples across all 4 slice boundaries.
- a = 0xDADA, b = 0xC9C9, cin = 1 → sum = 0xA4A4, cout = 1, p = 0.
- start, then start re-pulsed with a = 0x0001, b = 0x0001 during RUN:
  - the second start is ignored
  - the first result is unchanged
  - busy stays high for 4 cycles
  - exactly one done pulse
- start held high continuously with a = 0x1234, b = 0x1111, cin = 0 → back-to-back operations; done every 5th cycle; sum = 0x2345, cout = 0 each time.
- rst_n driven low during the 2nd RUN cycle → busy, done, sum, cout and p go to 0 immediately (asynchronously). After release, the next operation computes 0x0003 + 0x0004 = 0x0007 correctly.
